// File: rtl/ct_f_spsram_512x52_ctrl_pkg.sv
// rtl/ct_f_spsram_512x52_ctrl_pkg.sv - shared types and helpers for the 512x52 SRAM controller
package ct_f_spsram_ctrl_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int SRAM_DW = 52;
  localparam int HALF    = SRAM_DW / 2;

  // Half enables are active high; the macro write mask is active low per bit.
  function automatic logic [SRAM_DW-1:0] hen_to_wen(input logic [1:0] hen);
    return {{HALF{~hen[1]}}, {HALF{~hen[0]}}};
  endfunction

endpackage

// File: rtl/ct_f_spsram_512x52_ctrl_if.sv
// rtl/ct_f_spsram_512x52_ctrl_if.sv - request/response bus between requester and SRAM controller
interface ct_f_spsram_512x52_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 52
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_hen;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_hen, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_hen, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );
endinterface

// File: rtl/ct_f_spsram_512x52_ctrl_fifo.sv
// rtl/ct_f_spsram_512x52_ctrl_fifo.sv - flop-based synchronous FIFO with occupancy count
module ct_f_sync_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop & ~empty;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // The controller's credit check must make this unreachable.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/ct_f_spsram_512x52_ctrl.sv
// rtl/ct_f_spsram_512x52_ctrl.sv - zero-fill sweep plus registered request strobes for a 512x52 SRAM
module ct_f_spsram_512x52_ctrl
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = SRAM_DW,
  parameter int RSP_DEPTH  = 4,
  parameter int INIT_EN    = 1
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  ct_f_spsram_512x52_ctrl_if.slave bus,
  output logic                   init_done,
  output logic [ADDR_WIDTH-1:0]  sram_a,
  output logic                   sram_cen,
  output logic                   sram_gwen,
  output logic [DATA_WIDTH-1:0]  sram_wen,
  output logic [DATA_WIDTH-1:0]  sram_d,
  input  logic [DATA_WIDTH-1:0]  sram_q
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] a_nxt;
  logic [DATA_WIDTH-1:0] d_nxt, wen_nxt;
  logic                  cen_nxt, gwen_nxt;
  logic                  s1_rd, s1_rd_nxt, s2_rd;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           used;
  logic                  fifo_empty;
  logic                  accept;

  // Reads still in the SRAM pipe hold a FIFO slot; a same-cycle pop is not credited.
  assign used        = (CW+1)'(fifo_cnt) + (CW+1)'(s1_rd) + (CW+1)'(s2_rd);
  assign bus.req_rdy = init_done & (used < (CW+1)'(RSP_DEPTH));
  assign accept      = bus.req_vld & bus.req_rdy;
  assign bus.rsp_vld = ~fifo_empty;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = init_cnt;
    a_nxt     = sram_a;
    d_nxt     = sram_d;
    cen_nxt   = 1'b1;
    gwen_nxt  = 1'b1;
    wen_nxt   = '1;
    s1_rd_nxt = 1'b0;
    case (state)
      ST_INIT: begin
        if (INIT_EN != 0) begin
          cen_nxt  = 1'b0;
          gwen_nxt = 1'b0;
          wen_nxt  = '0;
          d_nxt    = '0;
          a_nxt    = init_cnt;
          cnt_nxt  = init_cnt + 1'b1;
          if (init_cnt == '1) state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (bus.req_wr) begin
            if (bus.req_hen != 2'b00) begin
              cen_nxt  = 1'b0;
              gwen_nxt = 1'b0;
              wen_nxt  = hen_to_wen(bus.req_hen);
              d_nxt    = bus.req_wdata;
              a_nxt    = bus.req_addr;
            end
          end else begin
            cen_nxt   = 1'b0;
            a_nxt     = bus.req_addr;
            s1_rd_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      sram_a    <= '0;
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;
      sram_d    <= '0;
      s1_rd     <= 1'b0;
      s2_rd     <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= cnt_nxt;
      init_done <= (state == ST_RUN);
      sram_a    <= a_nxt;
      sram_cen  <= cen_nxt;
      sram_gwen <= gwen_nxt;
      sram_wen  <= wen_nxt;
      sram_d    <= d_nxt;
      s1_rd     <= s1_rd_nxt;
      s2_rd     <= s1_rd;
    end
  end

  ct_f_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (forever_cpuclk),
    .rst_n (cpurst_b),
    .push  (s2_rd),
    .wdata (sram_q),
    .pop   (bus.rsp_vld & bus.rsp_rdy),
    .rdata (bus.rsp_rdata),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule
